// File: rtl/eth_rx_port_arb.sv
// eth_rx_port_arb: round-robin scheduler streaming per-port GMII receive FIFOs onto one core ingress bus.
// Optional saturating statistics counters are built when RX_ARB_STATS_EN is defined.
module eth_rx_port_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PW = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]    cmd_fifo_empty,
  output logic [NUM_PORTS-1:0]    cmd_fifo_re,
  input  logic [NUM_PORTS*72-1:0] cmd_fifo_dout,
  output logic [NUM_PORTS-1:0]    data_fifo_re,
  input  logic [NUM_PORTS*9-1:0]  data_fifo_dout,
  input  logic                   out_prog_full,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [PW-1:0]          out_port,
  output logic [10:0]            out_len
`ifdef RX_ARB_STATS_EN
  ,
  output logic [31:0]            stat_pkt_fwd,
  output logic [15:0]            stat_drop_crc,
  output logic [15:0]            stat_drop_del
`endif
);
  typedef enum logic [2:0] {IDLE, CMD_WAIT, XFER, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, grant, arb, idx;
  logic [10:0] len, rem;
  logic [71:0] cmd_sel;
  logic [8:0] data_sel;
  logic start, reading, first;
  logic unused_bits;
  assign cmd_sel = cmd_fifo_dout[72*int'(grant) +: 72];
  assign data_sel = data_fifo_dout[9*int'(grant) +: 9];
  assign unused_bits = ^{cmd_sel[71:54], cmd_sel[51:11], data_sel[8]};
  assign start = state == IDLE && !out_prog_full && !(&cmd_fifo_empty);
  assign reading = state == XFER || state == DRAIN;
  assign first = state == XFER && rem == len;
  // Descending scan so the port closest above rr_ptr is the last, winning assignment.
  always_comb begin
    arb = rr_ptr;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!cmd_fifo_empty[idx]) arb = idx;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = start ? CMD_WAIT : IDLE;
      CMD_WAIT:    state_nx = cmd_sel[10:0] == 11'd0 ? DONE : (cmd_sel[53] | cmd_sel[52]) ? DRAIN : XFER;
      XFER, DRAIN: state_nx = rem == 11'd1 ? DONE : state;
      default:     state_nx = IDLE;
    endcase
  end
  // cmd read is issued in the granting IDLE cycle so its word is ready in CMD_WAIT.
  always_comb begin
    cmd_fifo_re = reset && start ? NUM_PORTS'(1) << arb : '0;
    data_fifo_re = reading ? NUM_PORTS'(1) << grant : '0;
    out_data = out_valid ? data_sel[7:0] : 8'd0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rr_ptr <= '0;
      grant <= '0;
      len <= '0;
      rem <= '0;
    end else begin
      if (start) grant <= arb;
      if (state == CMD_WAIT) begin
        len <= cmd_sel[10:0];
        rem <= cmd_sel[10:0];
      end
      if (reading) rem <= rem - 11'd1;
      if (state == DONE) rr_ptr <= grant == PW'(NUM_PORTS - 1) ? '0 : grant + 1'b1;
    end
  // Byte read in cycle n is presented by the FIFO in cycle n+1, so the flags lag the read by one.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_port <= '0;
      out_len <= '0;
    end else begin
      out_valid <= state == XFER;
      out_sop <= first;
      out_eop <= state == XFER && rem == 11'd1;
      out_len <= first ? len : 11'd0;
      if (first) out_port <= grant;
    end
`ifdef RX_ARB_STATS_EN
  logic bad;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bad <= 1'b0;
      stat_pkt_fwd <= '0;
      stat_drop_crc <= '0;
      stat_drop_del <= '0;
    end else begin
      if (state == CMD_WAIT) begin
        bad <= cmd_sel[53] | cmd_sel[52];
        if (cmd_sel[53] && stat_drop_crc != '1) stat_drop_crc <= stat_drop_crc + 16'd1;
        if (cmd_sel[52] && !cmd_sel[53] && stat_drop_del != '1) stat_drop_del <= stat_drop_del + 16'd1;
      end
      if (state == DONE && !bad && len != 11'd0 && stat_pkt_fwd != '1) stat_pkt_fwd <= stat_pkt_fwd + 32'd1;
    end
`endif
endmodule

// File: tb/tb_eth_rx_port_arb.sv
// tb_eth_rx_port_arb: FIFO models plus an expected-byte scoreboard for eth_rx_port_arb.
module tb_eth_rx_port_arb;
  localparam int NP = 4;
  localparam int PW = 2;
  typedef struct {
    logic [7:0] d;
    logic sop;
    logic eop;
    logic [PW-1:0] port;
    logic [10:0] len;
  } exp_t;
  logic clk = 1'b0, reset = 1'b0, out_prog_full = 1'b0;
  logic [NP-1:0] cmd_fifo_empty = '1;
  logic [NP-1:0] cmd_fifo_re, data_fifo_re;
  logic [NP*72-1:0] cmd_fifo_dout = '0;
  logic [NP*9-1:0] data_fifo_dout = '0;
  logic out_valid, out_sop, out_eop;
  logic [7:0] out_data;
  logic [PW-1:0] out_port;
  logic [10:0] out_len;
`ifdef RX_ARB_STATS_EN
  logic [31:0] stat_pkt_fwd;
  logic [15:0] stat_drop_crc, stat_drop_del;
`endif
  logic [71:0] cmd_q[NP][$];
  logic [8:0] data_q[NP][$];
  exp_t exp_q[$];
  int tests = 0, fails = 0, rd_cnt = 0;

  eth_rx_port_arb #(.NUM_PORTS(NP), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_re(cmd_fifo_re), .cmd_fifo_dout(cmd_fifo_dout),
    .data_fifo_re(data_fifo_re), .data_fifo_dout(data_fifo_dout),
    .out_prog_full(out_prog_full), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port), .out_len(out_len)
`ifdef RX_ARB_STATS_EN
    , .stat_pkt_fwd(stat_pkt_fwd), .stat_drop_crc(stat_drop_crc), .stat_drop_del(stat_drop_del)
`endif
  );

  always #4 clk = ~clk;

  // Standard-mode FIFOs: dout updates on the edge that samples re.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (cmd_fifo_re[p] && cmd_q[p].size() > 0) cmd_fifo_dout[72*p +: 72] <= cmd_q[p].pop_front();
      if (data_fifo_re[p] && data_q[p].size() > 0) data_fifo_dout[9*p +: 9] <= data_q[p].pop_front();
      cmd_fifo_empty[p] <= cmd_q[p].size() == 0;
    end
    if (|data_fifo_re) rd_cnt <= rd_cnt + 1;
  end

  task automatic push_pkt(input int p, input int len, input logic [1:0] flags, input logic [7:0] base);
    logic [71:0] c;
    exp_t e;
    c = {8'($urandom), $urandom, $urandom};
    c[10:0] = 11'(len);
    c[53:52] = flags;
    for (int i = 0; i < len; i++) begin
      data_q[p].push_back({1'($urandom), 8'(int'(base) + i)});
      if (flags == 2'b00) begin
        e.d = 8'(int'(base) + i);
        e.sop = i == 0;
        e.eop = i == len - 1;
        e.port = PW'(p);
        e.len = 11'(len);
        exp_q.push_back(e);
      end
    end
    cmd_q[p].push_back(c);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    out_prog_full = 1'b0;
    for (int p = 0; p < NP; p++) begin
      cmd_q[p].delete();
      data_q[p].delete();
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push_pkt(0, 4, 2'b00, 8'h10);
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_fifo_re, data_fifo_re, out_valid, out_data, out_sop, out_eop, out_port, out_len} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got cmd_re=%b data_re=%b valid=%b data=%h sop=%b eop=%b port=%0d len=%0d, want all 0",
               cmd_fifo_re, data_fifo_re, out_valid, out_data, out_sop, out_eop, out_port, out_len);
    end
`ifdef RX_ARB_STATS_EN
    tests++;
    if ({stat_pkt_fwd, stat_drop_crc, stat_drop_del} !== '0) begin
      fails++;
      $display("FAIL reset stats: got fwd=%0d crc=%0d del=%0d, want 0", stat_pkt_fwd, stat_drop_crc, stat_drop_del);
    end
`endif
  endtask

  task automatic test_single();
    int cyc = 0, re_cyc = -1, sop_cyc = -1, last = -1, n = 0, gaps = 0;
    logic [NP-1:0] re_seen = '0;
    exp_t e;
    do_reset();
    push_pkt(0, 64, 2'b00, 8'h00);
    while (n < 64 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (|cmd_fifo_re && re_cyc < 0) begin
        re_cyc = cyc;
        re_seen = cmd_fifo_re;
      end
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL single stray: got data=%h, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
            fails++;
            $display("FAIL single byte %0d: got d=%h sop=%b eop=%b port=%0d len=%0d, want d=%h sop=%b eop=%b port=%0d len=%0d",
                     n, out_data, out_sop, out_eop, out_port, out_len, e.d, e.sop, e.eop, e.port, e.len);
          end
        end
        if (out_sop) sop_cyc = cyc;
        if (n > 0 && cyc != last + 1) gaps++;
        last = cyc;
        n++;
      end
    end
    tests++;
    if (n != 64) begin fails++; $display("FAIL single count: got %0d bytes, want 64", n); end
    tests++;
    if (re_seen !== 4'b0001) begin fails++; $display("FAIL single cmd_re: got %b, want 0001", re_seen); end
    tests++;
    if (sop_cyc - re_cyc != 3) begin fails++; $display("FAIL single latency: got %0d cycles, want 3", sop_cyc - re_cyc); end
    tests++;
    if (gaps != 0) begin fails++; $display("FAIL single gaps: got %0d, want 0", gaps); end
  endtask

  task automatic test_round_robin();
    int cyc = 0, n = 0, last_eop = -1;
    int g[$];
    exp_t e;
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) push_pkt(p, 60, 2'b00, 8'(p * 40 + k * 7));
    while (n < 480 && cyc < 700) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) if (cmd_fifo_re[p]) g.push_back(p);
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rr stray: got data=%h, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
            fails++;
            $display("FAIL rr byte %0d: got d=%h sop=%b eop=%b port=%0d len=%0d, want d=%h sop=%b eop=%b port=%0d len=%0d",
                     n, out_data, out_sop, out_eop, out_port, out_len, e.d, e.sop, e.eop, e.port, e.len);
          end
        end
        if (out_sop && last_eop >= 0) begin
          tests++;
          if (cyc - last_eop - 1 != 3) begin fails++; $display("FAIL rr gap: got %0d idle cycles, want 3", cyc - last_eop - 1); end
        end
        if (out_eop) last_eop = cyc;
        n++;
      end
    end
    tests++;
    if (n != 480) begin fails++; $display("FAIL rr count: got %0d bytes, want 480", n); end
    tests++;
    if (g.size() != 8) begin
      fails++;
      $display("FAIL rr grants: got %0d grants, want 8", g.size());
    end else
      for (int i = 0; i < 8; i++)
        if (g[i] != i % NP) begin fails++; $display("FAIL rr grant %0d: got port %0d, want %0d", i, g[i], i % NP); end
  endtask

  task automatic test_drop();
    int cyc = 0, n = 0, rd0, stray = 0;
    exp_t e;
    do_reset();
    rd0 = rd_cnt;
    push_pkt(1, 10, 2'b01, 8'h80);
    push_pkt(2, 100, 2'b10, 8'h90);
    push_pkt(2, 60, 2'b00, 8'h20);
    while (n < 60 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL drop stray: got data=%h, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
            fails++;
            $display("FAIL drop byte %0d: got d=%h sop=%b eop=%b port=%0d len=%0d, want d=%h sop=%b eop=%b port=%0d len=%0d",
                     n, out_data, out_sop, out_eop, out_port, out_len, e.d, e.sop, e.eop, e.port, e.len);
          end
        end
        n++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    tests++;
    if (n != 60 || stray != 0) begin fails++; $display("FAIL drop output: got %0d+%0d bytes, want 60+0", n, stray); end
    tests++;
    if (rd_cnt - rd0 != 170) begin fails++; $display("FAIL drop reads: got %0d, want 170", rd_cnt - rd0); end
`ifdef RX_ARB_STATS_EN
    tests++;
    if (stat_drop_crc !== 16'd1 || stat_drop_del !== 16'd1 || stat_pkt_fwd !== 32'd1) begin
      fails++;
      $display("FAIL drop stats: got crc=%0d del=%0d fwd=%0d, want 1 1 1", stat_drop_crc, stat_drop_del, stat_pkt_fwd);
    end
`endif
  endtask

  task automatic test_prog_full();
    int cyc = 0, n = 0, res = 0, busy = 0;
    exp_t e;
    do_reset();
    out_prog_full = 1'b1;
    push_pkt(0, 1500, 2'b00, 8'h00);
    push_pkt(1, 20, 2'b00, 8'h55);
    repeat (20) begin
      @(negedge clk);
      if (|cmd_fifo_re) res++;
    end
    tests++;
    if (res != 0) begin fails++; $display("FAIL pf blocked: got %0d cmd reads, want 0", res); end
    out_prog_full = 1'b0;
    while (n < 1520 && cyc < 1700) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pf stray: got data=%h, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
            fails++;
            $display("FAIL pf byte %0d: got d=%h sop=%b eop=%b port=%0d len=%0d, want d=%h sop=%b eop=%b port=%0d len=%0d",
                     n, out_data, out_sop, out_eop, out_port, out_len, e.d, e.sop, e.eop, e.port, e.len);
          end
        end
        n++;
        if (n == 100) out_prog_full = 1'b1;
        if (n == 1500) begin
          repeat (20) begin
            @(negedge clk);
            if (|cmd_fifo_re || out_valid) busy++;
          end
          tests++;
          if (busy != 0) begin fails++; $display("FAIL pf hold: got %0d active cycles, want 0", busy); end
          out_prog_full = 1'b0;
        end
      end
    end
    tests++;
    if (n != 1520) begin fails++; $display("FAIL pf count: got %0d bytes, want 1520", n); end
  endtask

  task automatic test_len1_len0();
    int cyc = 0, n = 0, rd0;
    int g[$];
    exp_t e;
    do_reset();
    rd0 = rd_cnt;
    push_pkt(1, 0, 2'b00, 8'h00);
    push_pkt(2, 4, 2'b00, 8'hC0);
    push_pkt(3, 1, 2'b00, 8'hA5);
    push_pkt(1, 4, 2'b00, 8'hE0);
    while (n < 9 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) if (cmd_fifo_re[p]) g.push_back(p);
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL len stray: got data=%h, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
            fails++;
            $display("FAIL len byte %0d: got d=%h sop=%b eop=%b port=%0d len=%0d, want d=%h sop=%b eop=%b port=%0d len=%0d",
                     n, out_data, out_sop, out_eop, out_port, out_len, e.d, e.sop, e.eop, e.port, e.len);
          end
        end
        n++;
      end
    end
    tests++;
    if (n != 9) begin fails++; $display("FAIL len count: got %0d bytes, want 9", n); end
    tests++;
    if (rd_cnt - rd0 != 9) begin fails++; $display("FAIL len reads: got %0d, want 9", rd_cnt - rd0); end
    tests++;
    if (g.size() != 4 || g[0] != 1 || g[1] != 2 || g[2] != 3 || g[3] != 1) begin
      fails++;
      $display("FAIL len grants: got %p, want '{1, 2, 3, 1}", g);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, n = 0;
    int g[$];
    exp_t e;
    do_reset();
    push_pkt(1, 8, 2'b00, 8'h40);
    push_pkt(2, 64, 2'b00, 8'h00);
    while (n < 38 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        tests++;
        e = exp_q.pop_front();
        if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
          fails++;
          $display("FAIL mid byte %0d: got d=%h sop=%b eop=%b port=%0d len=%0d, want d=%h sop=%b eop=%b port=%0d len=%0d",
                   n, out_data, out_sop, out_eop, out_port, out_len, e.d, e.sop, e.eop, e.port, e.len);
        end
        n++;
      end
    end
    #1 reset = 1'b0;
    #1;
    tests++;
    if (n != 38 || {cmd_fifo_re, data_fifo_re, out_valid, out_data, out_sop, out_eop, out_port, out_len} !== '0) begin
      fails++;
      $display("FAIL mid reset: got n=%0d data_re=%b valid=%b data=%h sop=%b eop=%b port=%0d, want n=38 and all 0",
               n, data_fifo_re, out_valid, out_data, out_sop, out_eop, out_port);
    end
    do_reset();
    push_pkt(0, 8, 2'b00, 8'h30);
    push_pkt(3, 8, 2'b00, 8'h70);
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) if (cmd_fifo_re[p]) g.push_back(p);
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL mid stray: got data=%h, want no output", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_port !== e.port || (e.sop && out_len !== e.len)) begin
            fails++;
            $display("FAIL mid after byte %0d: got d=%h port=%0d, want d=%h port=%0d", n, out_data, out_port, e.d, e.port);
          end
        end
        n++;
      end
    end
    tests++;
    if (n != 16 || g.size() == 0 || g[0] != 0) begin
      fails++;
      $display("FAIL mid restart: got %0d bytes first grant %0d, want 16 bytes first grant 0", n, g.size() > 0 ? g[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_prog_full();
    test_len1_len0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
